// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcode/funct
// values and the datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_LUIWB  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_LUI    = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI,
                      OP_XORI, OP_LUI, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and status in, enables and selects out.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic [1:0] memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       immzext;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, immzext, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg,
           alusrca, alusrcb, immzext, pcsrc, alucontrol
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operation and immediate-extension select, decoded from state, opcode and funct.
module mc_alu_dec
  import mc_pkg::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_immzext
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_alucontrol = ALU_AND;
    o_immzext    = 1'b0;
    case (i_state)
      S_FETCH, S_DECODE, S_MEMADR: o_alucontrol = ALU_ADD;
      S_BRANCH:                    o_alucontrol = ALU_SUB;
      S_EXEC: begin
        case (i_funct)
          F_SUB:   o_alucontrol = ALU_SUB;
          F_AND:   o_alucontrol = ALU_AND;
          F_OR:    o_alucontrol = ALU_OR;
          F_SLT:   o_alucontrol = ALU_SLT;
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      S_IEXEC: begin
        case (i_op)
          OP_ANDI: begin o_alucontrol = ALU_AND; o_immzext = 1'b1; end
          OP_ORI:  begin o_alucontrol = ALU_OR;  o_immzext = 1'b1; end
          OP_XORI: begin o_alucontrol = ALU_XOR; o_immzext = 1'b1; end
          default: o_alucontrol = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: state sequencing, per-state datapath controls and
// a retired-instruction counter.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  mc_ctrl_fsm_if.master    bus,
  output logic             o_illegal,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_retired
);

  state_e             r_state;
  state_e             w_next;
  logic               w_ready;
  logic               w_pcwrite;
  logic               w_branch;
  logic               w_irwrite;
  logic               w_regwrite;
  logic               w_memwrite;
  logic               w_retire;
  logic [2:0]         w_alucontrol;
  logic               w_immzext;
  logic [CNT_W-1:0]   r_retired;

  assign w_ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:                      w_next = S_MEMADR;
          OP_RTYPE:                          w_next = S_EXEC;
          OP_BEQ:                            w_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: w_next = S_IEXEC;
          OP_J:                              w_next = S_JUMP;
          OP_LUI:                            w_next = S_LUIWB;
          default:                           w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_IEXEC:  w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Enables are gated by reset so nothing writes while the async reset is held.
  always_comb begin
    bus.iord     = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = MTR_ALUOUT;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = SRCB_B;
    bus.pcsrc    = PCSRC_ALU;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_irwrite    = 1'b0;
    w_regwrite   = 1'b0;
    w_memwrite   = 1'b0;
    o_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.alusrcb = SRCB_FOUR;
        w_irwrite   = w_ready;
        w_pcwrite   = w_ready;
      end
      S_DECODE: begin
        bus.alusrcb = SRCB_BRIMM;
        o_illegal   = !is_legal_op(bus.op);
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEMRD: bus.iord = 1'b1;
      S_MEMWB: begin
        w_regwrite   = 1'b1;
        bus.memtoreg = MTR_MDR;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXEC: bus.alusrca = 1'b1;
      S_ALUWB: begin
        w_regwrite = 1'b1;
        bus.regdst = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.pcsrc   = PCSRC_ALUOUT;
        w_branch    = 1'b1;
      end
      S_IEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_IWB: w_regwrite = 1'b1;
      S_JUMP: begin
        bus.pcsrc = PCSRC_JUMP;
        w_pcwrite = 1'b1;
      end
      S_LUIWB: begin
        w_regwrite   = 1'b1;
        bus.memtoreg = MTR_LUI;
      end
      default: ;
    endcase
    bus.irwrite  = w_irwrite & ~reset;
    bus.regwrite = w_regwrite & ~reset;
    bus.memwrite = w_memwrite & ~reset;
    bus.pcen     = (w_pcwrite | (w_branch & bus.zero)) & ~reset;
  end

  mc_alu_dec u_alu_dec (
    .i_state      (r_state),
    .i_op         (bus.op),
    .i_funct      (bus.funct),
    .o_alucontrol (w_alucontrol),
    .o_immzext    (w_immzext)
  );

  assign bus.alucontrol = w_alucontrol;
  assign bus.immzext    = w_immzext;

  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
                                     S_IWB, S_JUMP, S_LUIWB});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  assign o_state   = r_state;
  assign o_retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction state paths from a table,
// expected outputs queued per cycle and compared on the falling edge.
module tb_mc_ctrl_fsm;
  import mc_pkg::*;

  typedef struct packed {
    logic [3:0]  state;
    logic        iord, memwrite, irwrite, pcen, regwrite, regdst;
    logic [1:0]  memtoreg;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic        immzext;
    logic [1:0]  pcsrc;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic [31:0] retired;
  } outs_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    int          len;
    logic [31:0] path;
    logic [7:0]  rdy;
    bit          retires;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] retired;
  int          n_checks;
  int          n_fail;
  int          exp_retired;
  outs_t       sb_q[$];
  vec_t        vecs[$];

  mc_ctrl_fsm_if bus();

  mc_ctrl_fsm #(.CNT_W(32), .MEM_WAIT_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .o_illegal (illegal),
    .o_state   (state),
    .o_retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Independent reading of the per-state control table.
  function automatic outs_t model(input logic [3:0] st, input logic [5:0] op,
                                  input logic [5:0] funct, input logic zero,
                                  input logic rdy, input int ret);
    outs_t o;
    o = '0;
    o.state   = st;
    o.retired = 32'(ret);
    case (st)
      4'd0: begin o.alusrcb = 2'b01; o.alucontrol = 3'b010; o.irwrite = rdy; o.pcen = rdy; end
      4'd1: begin
        o.alusrcb = 2'b11; o.alucontrol = 3'b010;
        o.illegal = !(op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
                      op == 6'h0c || op == 6'h0d || op == 6'h0e || op == 6'h0f ||
                      op == 6'h23 || op == 6'h2b);
      end
      4'd2: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
      4'd3: o.iord = 1'b1;
      4'd4: begin o.regwrite = 1'b1; o.memtoreg = 2'b01; end
      4'd5: begin o.iord = 1'b1; o.memwrite = 1'b1; end
      4'd6: begin
        o.alusrca = 1'b1;
        case (funct)
          6'h22: o.alucontrol = 3'b110;
          6'h24: o.alucontrol = 3'b000;
          6'h25: o.alucontrol = 3'b001;
          6'h2a: o.alucontrol = 3'b111;
          default: o.alucontrol = 3'b010;
        endcase
      end
      4'd7: begin o.regwrite = 1'b1; o.regdst = 1'b1; end
      4'd8: begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = zero; end
      4'd9: begin
        o.alusrca = 1'b1; o.alusrcb = 2'b10;
        case (op)
          6'h0c: begin o.alucontrol = 3'b000; o.immzext = 1'b1; end
          6'h0d: begin o.alucontrol = 3'b001; o.immzext = 1'b1; end
          6'h0e: begin o.alucontrol = 3'b011; o.immzext = 1'b1; end
          default: o.alucontrol = 3'b010;
        endcase
      end
      4'd10: o.regwrite = 1'b1;
      4'd11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      4'd12: begin o.regwrite = 1'b1; o.memtoreg = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  // Drive one cycle of inputs, queue what the DUT should show, advance to posedge+1.
  task automatic drive_cycle(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                             input logic rdy, input logic [3:0] exp_state);
    bus.op        = op;
    bus.funct     = funct;
    bus.zero      = zero;
    bus.mem_ready = rdy;
    sb_q.push_back(model(exp_state, op, funct, zero, rdy, exp_retired));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      outs_t e;
      outs_t a;
      e = sb_q.pop_front();
      a = '{state: state, iord: bus.iord, memwrite: bus.memwrite, irwrite: bus.irwrite,
            pcen: bus.pcen, regwrite: bus.regwrite, regdst: bus.regdst,
            memtoreg: bus.memtoreg, alusrca: bus.alusrca, alusrcb: bus.alusrcb,
            immzext: bus.immzext, pcsrc: bus.pcsrc, alucontrol: bus.alucontrol,
            illegal: illegal, retired: retired};
      check($sformatf("state%0d outputs", e.state), 64'(a), 64'(e));
    end
  end

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                              input int len, input logic [31:0] path, input logic [7:0] rdy,
                              input bit retires);
    vec_t v;
    v.op = op; v.funct = funct; v.zero = zero; v.len = len;
    v.path = path; v.rdy = rdy; v.retires = retires;
    return v;
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_retired = 0;
    reset         = 1'b1;
    bus.op        = 6'h00;
    bus.funct     = 6'h20;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Path nibbles are read most-significant first; rdy bits likewise.
    vecs.push_back(mk(6'h00, 6'h20, 1'b0, 4, 32'h0167_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h00, 6'h22, 1'b0, 4, 32'h0167_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h00, 6'h24, 1'b0, 4, 32'h0167_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h00, 6'h25, 1'b0, 4, 32'h0167_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h00, 6'h2a, 1'b0, 4, 32'h0167_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h00, 6'h3f, 1'b0, 4, 32'h0167_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h23, 6'h00, 1'b0, 7, 32'h0123_3340, 8'b1110_0110, 1'b1));
    vecs.push_back(mk(6'h23, 6'h00, 1'b0, 5, 32'h0123_4000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h2b, 6'h00, 1'b0, 4, 32'h0125_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h2b, 6'h00, 1'b0, 6, 32'h0012_5500, 8'b0111_0111, 1'b1));
    vecs.push_back(mk(6'h04, 6'h00, 1'b1, 3, 32'h0180_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h04, 6'h00, 1'b0, 3, 32'h0180_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h0f, 6'h00, 1'b0, 3, 32'h01c0_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h08, 6'h00, 1'b0, 4, 32'h019a_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h0c, 6'h00, 1'b0, 4, 32'h019a_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h0d, 6'h00, 1'b0, 4, 32'h019a_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h0e, 6'h00, 1'b0, 4, 32'h019a_0000, 8'hff, 1'b1));
    vecs.push_back(mk(6'h3f, 6'h00, 1'b0, 2, 32'h0100_0000, 8'hff, 1'b0));
    vecs.push_back(mk(6'h02, 6'h00, 1'b0, 3, 32'h01b0_0000, 8'hff, 1'b1));

    // Reset state, with enables forced low despite mem_ready being high.
    #2;
    check("reset state", 64'(state), 64'd0);
    check("reset retired", 64'(retired), 64'd0);
    check("reset enables", 64'({bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].len; i++) begin
        logic [31:0] p;
        logic [7:0]  r;
        p = vecs[k].path;
        r = vecs[k].rdy;
        drive_cycle(vecs[k].op, vecs[k].funct, vecs[k].zero, r[7-i], p[31-4*i -: 4]);
      end
      if (vecs[k].retires) exp_retired++;
    end

    // Abort a store stalled in MEMWR with an asynchronous reset.
    drive_cycle(OP_SW, 6'h00, 1'b0, 1'b1, 4'd0);
    drive_cycle(OP_SW, 6'h00, 1'b0, 1'b1, 4'd1);
    drive_cycle(OP_SW, 6'h00, 1'b0, 1'b1, 4'd2);
    drive_cycle(OP_SW, 6'h00, 1'b0, 1'b0, 4'd5);
    check("memwr stall state", 64'(state), 64'd5);
    check("memwr stall memwrite", 64'(bus.memwrite), 64'd1);
    #2;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("abort memwrite", 64'(bus.memwrite), 64'd0);
    check("abort state", 64'(state), 64'd0);
    check("abort retired", 64'(retired), 64'd0);
    check("abort enables", 64'({bus.irwrite, bus.pcen, bus.regwrite}), 64'd0);
    @(posedge clk);
    #1;
    check("held reset state", 64'(state), 64'd0);
    reset       = 1'b0;
    exp_retired = 0;

    // FETCH after reset waits on mem_ready, then a jump retires one instruction.
    drive_cycle(OP_J, 6'h00, 1'b0, 1'b0, 4'd0);
    drive_cycle(OP_J, 6'h00, 1'b0, 1'b0, 4'd0);
    drive_cycle(OP_J, 6'h00, 1'b0, 1'b1, 4'd0);
    drive_cycle(OP_J, 6'h00, 1'b0, 1'b1, 4'd1);
    drive_cycle(OP_J, 6'h00, 1'b0, 1'b1, 4'd11);
    exp_retired = 1;
    drive_cycle(OP_RTYPE, 6'h20, 1'b0, 1'b0, 4'd0);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle control unit that sequences a shared-ALU, single-memory MIPS datapath. The datapath has an instruction register, a memory data register and A/B/ALUOut registers. Each instruction is walked through FETCH/DECODE/execute/writeback states, with per-state enables and mux selects driven to the datapath. Supported ops: R-type (add/sub/and/or/slt), lw, sw, beq, addi, andi, ori, xori, j, lui. Memory accesses stall on a ready handshake, and retired instructions are counted.

Parameters:
CNT_W, 32, width of retired-instruction counter
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed current read/write this cycle
iord  out  1  0 = address from PC, 1 = from ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  load instruction register
pcen  out  1  PC load enable = pcwrite | (branch & zero)
regwrite  out  1  register file write
regdst  out  1  0 = rt, 1 = rd
memtoreg  out  2  00 ALUOut, 01 MDR, 10 imm<<16 (lui)
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 B, 01 const 4, 10 extended imm, 11 sign-imm<<2
immzext  out  1  1 = zero-extend imm (andi/ori/xori), 0 = sign-extend
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt
illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode
state  out  4  current state encoding, for debug
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: state = FETCH, retired = 0. While reset is high, all enables (irwrite, pcen, regwrite, memwrite) are forced to 0.
- Outputs are combinational from the state register, with op/funct for alucontrol and zero for pcen. Outputs not listed for a state are 0.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, LUIWB 12. Codes 13-15 return to FETCH.
- FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - lw/sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - addi/andi/ori/xori → IEXEC
  - j → JUMP
  - lui → LUIWB
  - other → FETCH with illegal=1 for that cycle; retired unchanged.
- MEMADR: alusrca=1, alusrcb=10, immzext=0, add. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1. Hold while mem_ready=0, then → MEMWB.
- MEMWB: regwrite, regdst=0, memtoreg=01. → FETCH.
- MEMWR: iord=1, memwrite=1 held until the cycle mem_ready=1 (inclusive). → FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol decoded from funct. An unknown funct drives 010, and the instruction still retires. → ALUWB.
- ALUWB: regwrite, regdst=1, memtoreg=00. → FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, branch=1 (pcen = zero). → FETCH.
- IEXEC: alusrca=1, alusrcb=10.
  - addi: add, immzext=0.
  - andi: and, immzext=1.
  - ori: or, immzext=1.
  - xori: xor, immzext=1.
  - → IWB.
- IWB: regwrite, regdst=0, memtoreg=00. → FETCH.
- JUMP: pcsrc=10, pcwrite. → FETCH.
- LUIWB: regwrite, regdst=0, memtoreg=10. → FETCH.
- Cycle counts with mem_ready tied high:
  - lw 5; sw 4; R-type 4; addi-family 4; beq 3; j 3; lui 3.
  - Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle.
- retired increments by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, IWB, JUMP or LUIWB. It wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts it: return to FETCH, no partial writes afterward, retired cleared.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings
  - opcode and funct constants
  - alucontrol, memtoreg, alusrcb and pcsrc encodings
- One sub-module, mc_alu_dec: combinational state/op/funct → alucontrol and immzext.
- The FSM, the output decode and the counter stay in mc_ctrl_fsm.

Test Plan:
- Reset, then op=000000 funct=100000, mem_ready=1 → states 0,1,6,7,0; regwrite=1 and regdst=1 only in state 7; alucontrol=010 in state 6; retired=1.
- op=100011 (lw) with mem_ready low 2 cycles in MEMRD → MEMRD lasts 3 cycles with iord=1; MEMWB has memtoreg=01; 7 cycles total.
- op=000100 (beq): zero=1 in BRANCH → pcen=1, pcsrc=01, alucontrol=110. Repeat with zero=0 → pcen=0; retired still increments.
- op=001111 (lui) → states 0,1,12,0; LUIWB has memtoreg=10, regdst=0, regwrite=1; 3 cycles.
- op=001101 (ori) → IEXEC has immzext=1, alucontrol=001, alusrcb=10. Then op=111111 → illegal pulses once in DECODE, back to FETCH, retired unchanged.
- Assert reset during MEMWR with mem_ready=0 → memwrite drops immediately, state=0, retired=0. After release the next FETCH waits on mem_ready.
